// File: rtl/mux_selftest_pkg.sv
// rtl/mux_selftest_pkg.sv - shared types and constants for the mux self-test sequencer
package mux_selftest_pkg;

  localparam int VEC_W        = 3;
  localparam int NUM_VEC      = 8;
  localparam int SETTLE_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/mux_golden_model.sv
// rtl/mux_golden_model.sv - reference 2:1 mux behaviour, z = b ? c : a
module mux_golden_model (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic exp
);

  // b selects c, otherwise a passes through
  assign exp = b ? c : a;

endmodule

// File: rtl/mux_selftest_ctrl.sv
// rtl/mux_selftest_ctrl.sv - walks all 8 mux input vectors and counts mismatches (option: MUX_SELFTEST_HALT_ON_FAIL_EN)
module mux_selftest_ctrl
  import mux_selftest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             mux_a,
  output logic             mux_b,
  output logic             mux_c,
  input  logic             mux_z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail
);

  localparam logic [ERR_W-1:0]        ERR_MAX  = '1;
  localparam logic [VEC_W-1:0]        VEC_LAST = VEC_W'(NUM_VEC - 1);
  localparam logic [SETTLE_CNT_W-1:0] CNT_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [VEC_W-1:0]        vec_q;
  logic [SETTLE_CNT_W-1:0] cnt_q;
  logic                    exp;
  logic                    mismatch;
  logic                    clr_run;
  logic                    load_cnt;
  logic                    dec_cnt;
  logic                    do_check;
  logic                    adv_vec;
  logic                    rst_vec;

  mux_golden_model u_golden (
    .a   (vec_q[2]),
    .b   (vec_q[1]),
    .c   (vec_q[0]),
    .exp (exp)
  );

  assign mismatch = (mux_z != exp);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath strobes; abort overrides everything, including a simultaneous start
  always_comb begin
    state_d  = state_q;
    clr_run  = 1'b0;
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    do_check = 1'b0;
    adv_vec  = 1'b0;
    rst_vec  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      rst_vec = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            clr_run = 1'b1;
            state_d = APPLY;
          end
        end
        APPLY: begin
          load_cnt = 1'b1;
          state_d  = SETTLE;
        end
        SETTLE: begin
          if (cnt_q == '0) state_d = CHECK;
          else             dec_cnt = 1'b1;
        end
        CHECK: begin
          do_check = 1'b1;
`ifdef MUX_SELFTEST_HALT_ON_FAIL_EN
          if (vec_q == VEC_LAST || mismatch) begin
`else
          if (vec_q == VEC_LAST) begin
`endif
            state_d = DONE;
          end else begin
            adv_vec = 1'b1;
            state_d = APPLY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Vector counter, settle timer and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q      <= '0;
      cnt_q      <= '0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      if (clr_run) begin
        vec_q      <= '0;
        err_count  <= '0;
        first_fail <= '0;
      end
      if (rst_vec) vec_q <= '0;
      if (adv_vec) vec_q <= vec_q + 1'b1;
      if (load_cnt) cnt_q <= CNT_LOAD;
      if (dec_cnt)  cnt_q <= cnt_q - 1'b1;
      if (do_check && mismatch) begin
        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
        if (err_count == '0)      first_fail <= vec_q;
      end
    end
  end

  assign mux_a = vec_q[2];
  assign mux_b = vec_q[1];
  assign mux_c = vec_q[0];
  assign busy  = (state_q == APPLY) || (state_q == SETTLE) || (state_q == CHECK);
  assign done  = (state_q == DONE);
  assign pass  = done && (err_count == '0);

endmodule

// File: tb/tb_mux_selftest_ctrl.sv
// tb/tb_mux_selftest_ctrl.sv - directed self-checking bench for mux_selftest_ctrl
module tb_mux_selftest_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       mux_a, mux_b, mux_c, mux_z;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;
  logic [1:0] mode;  // 0: healthy mux, 1: z stuck at 0, 2: z stuck at 1
  int         n_cmp = 0;
  int         n_err = 0;
  int         k;
  int         bcnt;

  mux_selftest_ctrl #(.SETTLE_CYCLES(2), .ERR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mux_a      (mux_a),
    .mux_b      (mux_b),
    .mux_c      (mux_c),
    .mux_z      (mux_z),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  assign mux_z = (mode == 2'd0) ? ((mux_a & ~mux_b) | (mux_b & mux_c)) :
                 (mode == 2'd1) ? 1'b0 : 1'b1;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a run, optionally re-pulse start at sample index pulse_at, wait for done (bounded)
  task automatic run(input int pulse_at, output int kk, output int bc);
    start = 1'b1;
    tick();
    start = 1'b0;
    kk = 0;
    bc = busy ? 1 : 0;
    while (!done && kk < 200) begin
      start = (kk == pulse_at);
      tick();
      kk++;
      if (busy) bc++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'd0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ff", first_fail, 0);
    chk("rst_abc", {mux_a, mux_b, mux_c}, 3'b000);
    rst_n = 1'b1;
    tick();

    // Healthy mux: 32 cycles busy, clean pass
    run(-1, k, bcnt);
    chk("ok_latency", k, 32);
    chk("ok_busy_cycles", bcnt, 32);
    chk("ok_done", done, 1);
    chk("ok_pass", pass, 1);
    chk("ok_err", err_count, 0);

    // z stuck at 0: fails on 011, 100, 101, 111
    mode = 2'd1;
    run(-1, k, bcnt);
`ifdef MUX_SELFTEST_HALT_ON_FAIL_EN
    chk("s0_latency", k, 16);
    chk("s0_err", err_count, 1);
`else
    chk("s0_latency", k, 32);
    chk("s0_err", err_count, 4);
`endif
    chk("s0_ff", first_fail, 3'b011);
    chk("s0_pass", pass, 0);
    chk("s0_done", done, 1);

    // z stuck at 1: abort during SETTLE of vec 5
    mode = 2'd2;
`ifdef MUX_SELFTEST_HALT_ON_FAIL_EN
    run(-1, k, bcnt);
    chk("s1_halt_latency", k, 4);
    chk("s1_halt_err", err_count, 1);
    chk("s1_halt_ff", first_fail, 3'b000);
`else
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (21) tick();
    chk("ab_pre_abc", {mux_a, mux_b, mux_c}, 3'b101);
    chk("ab_pre_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_abc", {mux_a, mux_b, mux_c}, 3'b000);
    chk("ab_err", err_count, 3);
    chk("ab_ff", first_fail, 3'b000);
`endif

    // start and abort together: abort wins, results retained
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_done", done, 0);
`ifdef MUX_SELFTEST_HALT_ON_FAIL_EN
    chk("sa_err", err_count, 1);
`else
    chk("sa_err", err_count, 3);
`endif

    // start re-pulsed while busy at vec 2 is ignored
    mode = 2'd0;
    run(9, k, bcnt);
    chk("rb_latency", k, 32);
    chk("rb_busy_cycles", bcnt, 32);
    chk("rb_pass", pass, 1);
    chk("rb_err", err_count, 0);

    // asynchronous reset in the middle of CHECK of vec 3
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("mr_pre_abc", {mux_a, mux_b, mux_c}, 3'b011);
    chk("mr_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_abc", {mux_a, mux_b, mux_c}, 3'b000);
    chk("mr_err", err_count, 0);
    #2 rst_n = 1'b1;
    tick();
    run(-1, k, bcnt);
    chk("mr_run_latency", k, 32);
    chk("mr_run_pass", pass, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
